multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 189 ++++++++++++++++++
 tb/tb_multicycle_controller.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-style control unit: a 12-state FSM that sequences fetch,
// decode, memory, ALU, branch and jump steps and drives the datapath
// selects, write enables and ALU operation.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       IorD,
  output logic       ALUSrcA,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUControl,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       PCEn,
  output logic       Illegal
);

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRd,
    StMemWb,
    StMemWr,
    StExecute,
    StAluWb,
    StBranch,
    StAddiExec,
    StAddiWb,
    StJump
  } state_e;

  state_e     state_q;
  logic [1:0] aluop;
  logic       alu_off;
  logic       pcwrite;
  logic       branch;

  // State register and next-state sequencing; reset wins over any wait.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      case (state_q)
        StFetch:    if (MemReady) state_q <= StDecode;
        StDecode: begin
          case (Opcode)
            OpLw, OpSw: state_q <= StMemAdr;
            OpRtype:    state_q <= StExecute;
            OpBeq:      state_q <= StBranch;
            OpAddi:     state_q <= StAddiExec;
            OpJ:        state_q <= StJump;
            default:    state_q <= StFetch;
          endcase
        end
        StMemAdr: begin
          if (Opcode == OpLw)      state_q <= StMemRd;
          else if (Opcode == OpSw) state_q <= StMemWr;
          else                     state_q <= StFetch;
        end
        StMemRd:    if (MemReady) state_q <= StMemWb;
        StMemWb:    state_q <= StFetch;
        StMemWr:    if (MemReady) state_q <= StFetch;
        StExecute:  state_q <= StAluWb;
        StAluWb:    state_q <= StFetch;
        StBranch:   state_q <= StFetch;
        StAddiExec: state_q <= StAddiWb;
        StAddiWb:   state_q <= StFetch;
        StJump:     state_q <= StFetch;
        default:    state_q <= StFetch;
      endcase
    end
  end

  // Output decode from the state register; during reset present FETCH
  // selects with every enable held low.
  always_comb begin
    IorD     = 1'b0;
    ALUSrcA  = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    ALUSrcB  = 2'b00;
    PCSrc    = 2'b00;
    aluop    = 2'b00;
    alu_off  = 1'b0;
    IRWrite  = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    Illegal  = 1'b0;
    if (reset) begin
      ALUSrcB = 2'b01;
    end else begin
      case (state_q)
        StFetch: begin
          ALUSrcB = 2'b01;
          IRWrite = MemReady;
          pcwrite = MemReady;
        end
        StDecode: begin
          ALUSrcB = 2'b11;
          case (Opcode)
            OpLw, OpSw, OpRtype, OpBeq, OpAddi, OpJ: Illegal = 1'b0;
            default:                                 Illegal = 1'b1;
          endcase
        end
        StMemAdr: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        StMemRd:  IorD = 1'b1;
        StMemWb: begin
          MemtoReg = 1'b1;
          RegWrite = 1'b1;
        end
        StMemWr: begin
          IorD     = 1'b1;
          MemWrite = 1'b1;
        end
        StExecute: begin
          ALUSrcA = 1'b1;
          aluop   = 2'b10;
        end
        StAluWb: begin
          RegDst   = 1'b1;
          RegWrite = 1'b1;
        end
        StBranch: begin
          ALUSrcA = 1'b1;
          aluop   = 2'b01;
          PCSrc   = 2'b01;
          branch  = 1'b1;
        end
        StAddiExec: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        StAddiWb: RegWrite = 1'b1;
        StJump: begin
          PCSrc   = 2'b10;
          pcwrite = 1'b1;
        end
        // Unreachable encodings drive every output, ALUControl included, to 0.
        default: alu_off = 1'b1;
      endcase
    end
  end

  // ALU operation from ALUOp and, for R-type, the function field.
  always_comb begin
    ALUControl = 3'b010;
    if (alu_off) begin
      ALUControl = 3'b000;
    end else begin
      case (aluop)
        2'b01: ALUControl = 3'b110;
        2'b10: begin
          case (Funct)
            6'b100000: ALUControl = 3'b010;
            6'b100010: ALUControl = 3'b110;
            6'b100100: ALUControl = 3'b000;
            6'b100101: ALUControl = 3'b001;
            6'b101010: ALUControl = 3'b111;
            default:   ALUControl = 3'b010;
          endcase
        end
        default: ALUControl = 3'b010;
      endcase
    end
  end

  assign PCEn = pcwrite | (branch & Zero);

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed scenarios followed
// by random instruction streams, compared cycle by cycle against a per-step
// model of what each instruction class should present.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       Zero;
  logic       MemReady;
  logic       IorD, ALUSrcA, RegDst, MemtoReg;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUControl;
  logic       IRWrite, MemWrite, RegWrite, PCEn, Illegal;

  int checks = 0;
  int errors = 0;

  // Instruction steps as seen by the datapath.
  localparam int PFetch  = 0;
  localparam int PDec    = 1;
  localparam int PDecIll = 2;
  localparam int PAddr   = 3;
  localparam int PRead   = 4;
  localparam int PLoadWb = 5;
  localparam int PWrite  = 6;
  localparam int PExec   = 7;
  localparam int PAluWb  = 8;
  localparam int PBeq    = 9;
  localparam int PAddi   = 10;
  localparam int PAddiWb = 11;
  localparam int PJmp    = 12;
  localparam int PReset  = 13;

  multicycle_controller dut (
    .clk       (clk),
    .reset     (reset),
    .Opcode    (Opcode),
    .Funct     (Funct),
    .Zero      (Zero),
    .MemReady  (MemReady),
    .IorD      (IorD),
    .ALUSrcA   (ALUSrcA),
    .RegDst    (RegDst),
    .MemtoReg  (MemtoReg),
    .ALUSrcB   (ALUSrcB),
    .PCSrc     (PCSrc),
    .ALUControl(ALUControl),
    .IRWrite   (IRWrite),
    .MemWrite  (MemWrite),
    .RegWrite  (RegWrite),
    .PCEn      (PCEn),
    .Illegal   (Illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] alu_of_funct(input logic [5:0] fn);
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Packed as {IorD,ALUSrcA,RegDst,MemtoReg,ALUSrcB,PCSrc,ALUControl,
  //            IRWrite,MemWrite,RegWrite,PCEn,Illegal}.
  function automatic logic [15:0] expect_out(input int ph, input logic mr, input logic z,
                                             input logic [5:0] fn);
    logic       iord, asa, rdst, m2r, irw, mw, rw, pce, ill;
    logic [1:0] asb, pcs;
    logic [2:0] aluc;
    iord = 0; asa = 0; rdst = 0; m2r = 0; irw = 0; mw = 0; rw = 0; pce = 0; ill = 0;
    asb = 2'b00; pcs = 2'b00; aluc = 3'b010;
    case (ph)
      PFetch:  begin asb = 2'b01; irw = mr; pce = mr; end
      PDec:    asb = 2'b11;
      PDecIll: begin asb = 2'b11; ill = 1; end
      PAddr:   begin asa = 1; asb = 2'b10; end
      PRead:   iord = 1;
      PLoadWb: begin m2r = 1; rw = 1; end
      PWrite:  begin iord = 1; mw = 1; end
      PExec:   begin asa = 1; aluc = alu_of_funct(fn); end
      PAluWb:  begin rdst = 1; rw = 1; end
      PBeq:    begin asa = 1; aluc = 3'b110; pcs = 2'b01; pce = z; end
      PAddi:   begin asa = 1; asb = 2'b10; end
      PAddiWb: rw = 1;
      PJmp:    begin pcs = 2'b10; pce = 1; end
      PReset:  asb = 2'b01;
      default: aluc = 3'b010;
    endcase
    return {iord, asa, rdst, m2r, asb, pcs, aluc, irw, mw, rw, pce, ill};
  endfunction

  // Drive MemReady, settle, compare, then advance one clock.
  task automatic step(input int ph, input logic mr, input string tag);
    logic [15:0] obs, exp_v;
    MemReady = mr;
    #1;
    obs = {IorD, ALUSrcA, RegDst, MemtoReg, ALUSrcB, PCSrc, ALUControl,
           IRWrite, MemWrite, RegWrite, PCEn, Illegal};
    exp_v = expect_out(ph, mr, Zero, Funct);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s step=%0d: got %b expected %b", tag, ph, obs, exp_v);
    end
    @(posedge clk);
    #1;
  endtask

  // Runs one whole instruction; fstall/mstall are MemReady-low cycles in the
  // fetch and data-memory waits.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int fstall, input int mstall, input string tag);
    int q[$];
    int stalls;
    Opcode = op;
    Funct  = fn;
    Zero   = z;
    q.push_back(PFetch);
    case (op)
      6'b100011: begin q.push_back(PDec); q.push_back(PAddr); q.push_back(PRead);
                       q.push_back(PLoadWb); end
      6'b101011: begin q.push_back(PDec); q.push_back(PAddr); q.push_back(PWrite); end
      6'b000000: begin q.push_back(PDec); q.push_back(PExec); q.push_back(PAluWb); end
      6'b000100: begin q.push_back(PDec); q.push_back(PBeq); end
      6'b001000: begin q.push_back(PDec); q.push_back(PAddi); q.push_back(PAddiWb); end
      6'b000010: begin q.push_back(PDec); q.push_back(PJmp); end
      default:   q.push_back(PDecIll);
    endcase
    foreach (q[i]) begin
      if (q[i] == PFetch) stalls = fstall;
      else if (q[i] == PRead || q[i] == PWrite) stalls = mstall;
      else stalls = -1;
      if (stalls < 0) begin
        step(q[i], 1'($urandom_range(0, 1)), tag);
      end else begin
        for (int k = 0; k < stalls; k++) step(q[i], 1'b0, tag);
        step(q[i], 1'b1, tag);
      end
    end
  endtask

  initial begin
    logic [5:0] ops [6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    logic [5:0] fns [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [5:0] op, fn;
    int sel;

    // Reset: enables stay low even with MemReady and Zero high.
    reset = 1'b1; MemReady = 1'b1; Opcode = 6'b000100; Funct = 6'b0; Zero = 1'b1;
    @(posedge clk);
    #1;
    step(PReset, 1'b1, "reset_a");
    step(PReset, 1'b1, "reset_b");
    reset = 1'b0;

    run_instr(6'b000000, 6'b100010, 1'b0, 0, 0, "rtype_sub");
    run_instr(6'b100011, 6'b000000, 1'b0, 0, 2, "lw_stall2");
    run_instr(6'b000100, 6'b000000, 1'b1, 0, 0, "beq_taken");
    run_instr(6'b000100, 6'b000000, 1'b0, 1, 0, "beq_not_taken");
    run_instr(6'b111111, 6'b000000, 1'b0, 0, 0, "illegal");
    run_instr(6'b000010, 6'b000000, 1'b1, 0, 0, "jump");
    run_instr(6'b001000, 6'b000000, 1'b0, 2, 0, "addi");
    run_instr(6'b101011, 6'b000000, 1'b0, 0, 1, "sw_stall1");

    // Reset mid-store while memory is still busy.
    Opcode = 6'b101011; Funct = 6'b0; Zero = 1'b0;
    step(PFetch, 1'b1, "swrst_fetch");
    step(PDec, 1'b1, "swrst_dec");
    step(PAddr, 1'b1, "swrst_addr");
    step(PWrite, 1'b0, "swrst_wait");
    reset = 1'b1;
    step(PReset, 1'b0, "swrst_in_reset");
    reset = 1'b0;
    step(PFetch, 1'b0, "swrst_refetch");

    for (int n = 0; n < 150; n++) begin
      sel = int'($urandom_range(0, 6));
      op  = (sel == 6) ? 6'($urandom_range(0, 63)) : ops[sel];
      sel = int'($urandom_range(0, 5));
      fn  = (sel == 5) ? 6'($urandom_range(0, 63)) : fns[sel];
      run_instr(op, fn, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 3)), $sformatf("rand%0d_op%b", n, op));
    end
    step(PFetch, 1'b0, "final_fetch");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
